// File: rtl/ras_pkg.sv
// Shared definitions for the return address stack and the datapath PC-select logic.
package ras_pkg;

    localparam int unsigned PC_W              = 12;
    localparam int unsigned RAS_DEPTH_DEFAULT = 8;

    typedef logic [PC_W-1:0] pc_addr_t;

    // Encoding is {push, pop} so a request pair maps straight onto an operation.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_REPL = 2'b11
    } ras_op_e;

endpackage

// File: rtl/ras_mem.sv
// DEPTH x WIDTH register array: asynchronous read, synchronous write, asynchronous clear.
module ras_mem
    import ras_pkg::*;
#(
    parameter int unsigned DEPTH = RAS_DEPTH_DEFAULT,
    parameter int unsigned WIDTH = PC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/return_address_stack.sv
// Hardware call/return stack with occupancy and sticky error flags.
// Define RAS_WRAP_EN to make a push while full overwrite the oldest entry.
module return_address_stack
    import ras_pkg::*;
#(
    parameter int unsigned DEPTH = RAS_DEPTH_DEFAULT,
    parameter int unsigned WIDTH = PC_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       stack_overflow,
    output logic                       stack_underflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [PW-1:0]    top;
    logic [PW-1:0]    top_nxt;
    logic [CW-1:0]    count_nxt;
    logic             mem_we;
    logic [PW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_rdata;
    logic             ovf_set;
    logic             unf_set;
    ras_op_e          op;

    assign op    = ras_op_e'({push, pop});
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // top indexes the current top entry; a push always lands one slot above it,
    // which when full is also the oldest entry (the wrap overwrite target).
    always_comb begin
        top_nxt   = top;
        count_nxt = count;
        mem_we    = 1'b0;
        mem_waddr = top + PW'(1);
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        unique case (op)
            OP_PUSH: begin
                if (!full) begin
                    mem_we    = 1'b1;
                    top_nxt   = top + PW'(1);
                    count_nxt = count + CW'(1);
                end else begin
                    ovf_set = 1'b1;
`ifdef RAS_WRAP_EN
                    mem_we  = 1'b1;
                    top_nxt = top + PW'(1);
`endif
                end
            end
            OP_POP: begin
                if (empty) begin
                    unf_set = 1'b1;
                end else begin
                    top_nxt   = top - PW'(1);
                    count_nxt = count - CW'(1);
                end
            end
            OP_REPL: begin
                mem_we = 1'b1;
                if (empty) begin
                    unf_set   = 1'b1;
                    top_nxt   = top + PW'(1);
                    count_nxt = count + CW'(1);
                end else begin
                    mem_waddr = top;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top             <= '0;
            count           <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            top             <= top_nxt;
            count           <= count_nxt;
            stack_overflow  <= stack_overflow | ovf_set;
            stack_underflow <= stack_underflow | unf_set;
        end
    end

    ras_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (data_in),
        .raddr (top),
        .rdata (mem_rdata)
    );

    // Popped entries are left in storage, so mask the read when empty.
    assign data_out = empty ? '0 : mem_rdata;

endmodule

// File: tb/tb_return_address_stack.sv
// Directed bench for return_address_stack: vector table plus corner-case sequences.
module tb_return_address_stack;

    logic        clk;
    logic        rst;
    logic        push;
    logic        pop;
    logic [11:0] data_in;
    logic [11:0] data_out;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic        stack_overflow;
    logic        stack_underflow;

    int n_tests = 0;
    int n_fail  = 0;

    return_address_stack #(
        .DEPTH (8),
        .WIDTH (12)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .push            (push),
        .pop             (pop),
        .data_in         (data_in),
        .data_out        (data_out),
        .empty           (empty),
        .full            (full),
        .count           (count),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic        pop;
        logic [11:0] din;
        logic [11:0] out;
        int          cnt;
        logic        emp;
        logic        ful;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic pu, input logic po, input logic [11:0] din,
                                input logic [11:0] out, input int cnt, input logic emp,
                                input logic ful, input logic ovf, input logic unf);
        vec_t v;
        v.push = pu; v.pop = po; v.din = din; v.out = out; v.cnt = cnt;
        v.emp = emp; v.ful = ful; v.ovf = ovf; v.unf = unf;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one request at the falling edge, let it take effect, then go idle.
    task automatic step(input logic pu, input logic po, input logic [11:0] din);
        @(negedge clk);
        push = pu; pop = po; data_in = din;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        push = 1'b0; pop = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [11:0] pop_exp [8];

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset.data_out", int'(data_out), 0);
        check("reset.count", int'(count), 0);
        check("reset.empty", int'(empty), 1);
        check("reset.full", int'(full), 0);
        check("reset.ovf", int'(stack_overflow), 0);
        check("reset.unf", int'(stack_underflow), 0);

        //   push pop  din     out    cnt emp ful ovf unf
        add(0, 0, 12'h000, 12'h000, 0, 1, 0, 0, 0);
        add(1, 0, 12'h011, 12'h011, 1, 0, 0, 0, 0);
        add(1, 0, 12'h022, 12'h022, 2, 0, 0, 0, 0);
        add(1, 0, 12'h033, 12'h033, 3, 0, 0, 0, 0);
        add(0, 1, 12'h000, 12'h022, 2, 0, 0, 0, 0);
        add(0, 1, 12'h000, 12'h011, 1, 0, 0, 0, 0);
        add(0, 1, 12'h000, 12'h000, 0, 1, 0, 0, 0);
        add(0, 1, 12'h000, 12'h000, 0, 1, 0, 0, 1);
        add(1, 0, 12'h0AA, 12'h0AA, 1, 0, 0, 0, 1);
        add(1, 0, 12'h055, 12'h055, 2, 0, 0, 0, 1);
        add(1, 1, 12'h0CC, 12'h0CC, 2, 0, 0, 0, 1);
        add(0, 1, 12'h000, 12'h0AA, 1, 0, 0, 0, 1);
        add(0, 1, 12'h000, 12'h000, 0, 1, 0, 0, 1);
        add(1, 1, 12'h0CC, 12'h0CC, 1, 0, 0, 0, 1);
        add(0, 1, 12'h000, 12'h000, 0, 1, 0, 0, 1);

        foreach (vecs[i]) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].din);
            check($sformatf("vec%0d.data_out", i), int'(data_out), int'(vecs[i].out));
            check($sformatf("vec%0d.count", i), int'(count), vecs[i].cnt);
            check($sformatf("vec%0d.empty", i), int'(empty), int'(vecs[i].emp));
            check($sformatf("vec%0d.full", i), int'(full), int'(vecs[i].ful));
            check($sformatf("vec%0d.ovf", i), int'(stack_overflow), int'(vecs[i].ovf));
            check($sformatf("vec%0d.unf", i), int'(stack_underflow), int'(vecs[i].unf));
        end

        // Top of stack is visible combinationally while the pop is pending.
        do_reset();
        step(1, 0, 12'h011);
        step(1, 0, 12'h022);
        step(1, 0, 12'h033);
        @(negedge clk);
        pop = 1'b1;
        #1;
        check("prepop.data_out", int'(data_out), 'h033);
        check("prepop.count", int'(count), 3);
        @(posedge clk);
        #1;
        pop = 1'b0;
        check("postpop.data_out", int'(data_out), 'h022);

        // Fill to capacity, then push once more.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 12'h100 + 12'(i));
        end
        check("fill.full", int'(full), 1);
        check("fill.count", int'(count), 8);
        check("fill.data_out", int'(data_out), 'h107);
        check("fill.ovf", int'(stack_overflow), 0);
        step(1, 0, 12'h1FF);
        check("ovf.count", int'(count), 8);
        check("ovf.full", int'(full), 1);
        check("ovf.flag", int'(stack_overflow), 1);
`ifdef RAS_WRAP_EN
        pop_exp[0] = 12'h1FF;
        for (int i = 1; i < 8; i++) pop_exp[i] = 12'h108 - 12'(i);
`else
        for (int i = 0; i < 8; i++) pop_exp[i] = 12'h107 - 12'(i);
`endif
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d.data_out", i), int'(data_out), int'(pop_exp[i]));
            step(0, 1, 12'h000);
        end
        check("drain.empty", int'(empty), 1);
        check("drain.data_out", int'(data_out), 0);
        check("drain.unf", int'(stack_underflow), 0);
        check("drain.ovf_sticky", int'(stack_overflow), 1);

        // Asynchronous reset between edges with a push pending.
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 12'h200 + 12'(i));
        end
        check("pre_arst.count", int'(count), 5);
        @(negedge clk);
        push = 1'b1; data_in = 12'h3AB;
        #2;
        rst = 1'b1;
        #1;
        check("arst.count", int'(count), 0);
        check("arst.empty", int'(empty), 1);
        check("arst.full", int'(full), 0);
        check("arst.data_out", int'(data_out), 0);
        check("arst.ovf", int'(stack_overflow), 0);
        check("arst.unf", int'(stack_underflow), 0);
        @(posedge clk);
        #1;
        check("arst_hold.count", int'(count), 0);
        @(negedge clk);
        push = 1'b0;
        rst = 1'b0;
        #1;
        check("arst_rel.count", int'(count), 0);
        check("arst_rel.data_out", int'(data_out), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
